aes_inv_sub_bytes_seq: RTL and testbench

// - Iterative AES InvSubBytes engine; inverse of the forward S-box path used by encryption.
// - Accepts one 128-bit state and replaces every byte b with InvSbox(b), i.e. the x such that Sbox(x) == b.
// - Uses BYTES_PER_CYCLE inverse S-box lookups per clock and returns the result over a valid/ready handshake.
// - Sits in the decryption round datapath, between InvShiftRows and AddRoundKey.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_inv_sbox.sv | 28 ++
 rtl/aes_inv_sub_bytes_seq.sv | 112 +++++++++++
 tb/tb_aes_inv_sub_bytes_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, engine FSM encoding and byte-extraction helper.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] get_byte(input logic [AES_BLOCK_W-1:0] blk, input logic [3:0] idx);
    return blk[8*(4'd15 - idx) +: 8];
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// FIPS-197 inverse S-box: combinational 8-bit lookup.
module aes_inv_sbox (
  input  logic [7:0] inv_sboxw,
  output logic [7:0] new_inv_sboxw
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign new_inv_sboxw = INV_SBOX[inv_sboxw];

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Iterative InvSubBytes engine: substitutes BYTES_PER_CYCLE bytes per clock in a working
// register and hands the finished state out over a valid/ready handshake.
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic                   busy
);

  localparam int unsigned N_GROUPS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned CNT_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_GROUPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("aes_inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [AES_BLOCK_W-1:0] work, work_d;
  logic [AES_BLOCK_W-1:0] out_block_d;
  logic                   in_ready_d, out_valid_d, busy_d;

  logic [3:0] sel      [BYTES_PER_CYCLE];
  logic [7:0] sbox_in  [BYTES_PER_CYCLE];
  logic [7:0] sbox_out [BYTES_PER_CYCLE];

  // One lookup per lane; lane g works on byte cnt*BYTES_PER_CYCLE + g.
  for (genvar g = 0; g < int'(BYTES_PER_CYCLE); g++) begin : g_lane
    assign sel[g]     = 4'(32'(cnt) * BYTES_PER_CYCLE + 32'(g));
    assign sbox_in[g] = get_byte(work, sel[g]);

    aes_inv_sbox u_inv_sbox (
      .inv_sboxw     (sbox_in[g]),
      .new_inv_sboxw (sbox_out[g])
    );
  end

  // Next-state, in-place write-back and next registered outputs.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    work_d      = work;
    out_block_d = out_block;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = in_block;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(AES_BYTES); i++) begin
          for (int g = 0; g < int'(BYTES_PER_CYCLE); g++) begin
            if (sel[g] == 4'(i)) begin
              work_d[8*(int'(AES_BYTES)-1-i) +: 8] = sbox_out[g];
            end
          end
        end
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_d       = '0;
          out_block_d = work_d;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      out_block <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      work      <= work_d;
      out_block <= out_block_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Directed bench for aes_inv_sub_bytes_seq: one instance with 1 lane, one with 4 lanes.
module tb_aes_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   in_valid;
  logic [1:0]   out_ready;
  logic [127:0] in_block [2];

  logic         in_ready0, out_valid0, busy0;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] out_block0, out_block1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready0), .in_block(in_block[0]),
    .out_valid(out_valid0), .out_ready(out_ready[0]), .out_block(out_block0), .busy(busy0)
  );

  aes_inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready1), .in_block(in_block[1]),
    .out_valid(out_valid1), .out_ready(out_ready[1]), .out_block(out_block1), .busy(busy1)
  );

  // Forward FIPS-197 S-box; the expected inverse is derived from it by search.
  logic [7:0] sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] inv_ref(input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 256; i++) if (sbox[i] == b) r = 8'(i);
    return r;
  endfunction

  function automatic logic [127:0] inv_blk(input logic [127:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_ref(blk[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] fwd_blk(input logic [127:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[blk[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? in_ready0 : in_ready1;
  endfunction

  function automatic logic ov(input int d);
    return (d == 0) ? out_valid0 : out_valid1;
  endfunction

  function automatic logic [127:0] ob(input int d);
    return (d == 0) ? out_block0 : out_block1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one block, count edges (accept edge included) until out_valid, then drain.
  task automatic xfer(input int d, input logic [127:0] blk, input bit rnd, input bit noise,
                      output logic [127:0] res, output int lat);
    int guard;
    bit done;
    guard = 0;
    while (!rdy(d) && guard < 50) begin tick(); guard++; end
    chk("accept_ready", 128'(rdy(d)), 128'(1));
    in_valid[d] = 1'b1;
    in_block[d] = blk;
    tick();
    lat = 1;
    in_valid[d] = 1'b0;
    while (!ov(d) && lat < 100) begin
      if (noise) begin
        in_valid[d] = 1'($urandom);
        in_block[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      lat++;
    end
    chk("out_valid_rise", 128'(ov(d)), 128'(1));
    res = ob(d);
    done = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      out_ready[d] = rnd ? 1'($urandom) : 1'b1;
      if (noise) begin
        in_valid[d] = 1'($urandom);
        in_block[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      chk("hold_block", ob(d), res);
      done = out_ready[d] && ov(d);
      tick();
      guard++;
    end
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    chk("handshake_done", 128'(done), 128'(1));
    chk("valid_fall", 128'(ov(d)), 128'(0));
    chk("block_kept_after_done", ob(d), res);
  endtask

  initial begin
    logic [127:0] res, blk, held;
    int lat, guard;
    bit seen;

    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b00;
    in_block[0] = '0;
    in_block[1] = '0;

    // Reset state.
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready0), 128'(0));
    chk("rst_out_valid", 128'(out_valid0), 128'(0));
    chk("rst_out_block", out_block0, 128'h0);
    chk("rst_busy", 128'(busy0), 128'(0));
    chk("rst_in_ready_x4", 128'(in_ready1), 128'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 128'(in_ready0), 128'(1));
    chk("post_rst_in_ready_x4", 128'(in_ready1), 128'(1));

    // Single block, one lane.
    xfer(0, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b0, 1'b0, res, lat);
    chk("single_block", res, 128'h000102030405060708090a0b0c0d0e0f);
    chk("latency_x1", 128'(lat), 128'(17));

    // Uniform blocks on both widths.
    xfer(0, {16{8'h63}}, 1'b0, 1'b0, res, lat);
    chk("all63_x1", res, 128'h0);
    xfer(0, {16{8'h16}}, 1'b0, 1'b0, res, lat);
    chk("all16_x1", res, {16{8'hff}});
    xfer(1, {16{8'h63}}, 1'b0, 1'b0, res, lat);
    chk("all63_x4", res, 128'h0);
    chk("latency_x4", 128'(lat), 128'(5));
    xfer(1, {16{8'h16}}, 1'b0, 1'b0, res, lat);
    chk("all16_x4", res, {16{8'hff}});
    chk("latency_x4_b", 128'(lat), 128'(5));
    xfer(1, {16{8'h52}}, 1'b0, 1'b0, res, lat);
    chk("all52_x4", res, {16{8'h48}});

    // Backpressure: hold out_ready low for 10 cycles.
    in_valid[0] = 1'b1;
    in_block[0] = {16{8'h00}};
    tick();
    in_valid[0] = 1'b0;
    guard = 0;
    while (!out_valid0 && guard < 40) begin tick(); guard++; end
    chk("bp_valid", 128'(out_valid0), 128'(1));
    held = out_block0;
    chk("bp_value", held, {16{8'h52}});
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_valid_hold", 128'(out_valid0), 128'(1));
      chk("bp_block_hold", out_block0, held);
      chk("bp_in_ready_low", 128'(in_ready0), 128'(0));
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("bp_in_ready_after", 128'(in_ready0), 128'(1));
    chk("bp_valid_after", 128'(out_valid0), 128'(0));

    // Ignored input while RUN/DONE.
    xfer(0, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b1, 1'b1, res, lat);
    chk("noise_x1", res, 128'h000102030405060708090a0b0c0d0e0f);
    xfer(1, {16{8'h7c}}, 1'b1, 1'b1, res, lat);
    chk("noise_x4", res, {16{8'h01}});

    // Reset in RUN cycle 5.
    in_valid[0] = 1'b1;
    in_block[0] = {16{8'h63}};
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    chk("midrun_busy", 128'(busy0), 128'(1));
    rst = 1'b1;
    tick();
    chk("midrun_rst_in_ready", 128'(in_ready0), 128'(0));
    chk("midrun_rst_busy", 128'(busy0), 128'(0));
    chk("midrun_rst_block", out_block0, 128'h0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      seen |= out_valid0;
    end
    chk("midrun_no_valid", 128'(seen), 128'(0));
    chk("midrun_idle_ready", 128'(in_ready0), 128'(1));

    // Exhaustive round trip: 16 blocks covering 00..ff.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = 8'(16*k + j);
      xfer(1, blk, 1'b1, 1'b0, res, lat);
      chk("exh_inv", res, inv_blk(blk));
      chk("exh_roundtrip", fwd_blk(res), blk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
